pwm_duty_ramp_sequencer: RTL and testbench

//   Controller for the PWM duty-cycle register. It sits between the SPI register bank and pwm_peripheral.

---
 rtl/pwm_seq_pkg.sv | 12 +
 rtl/pwm_seq_tick.sv | 22 ++
 rtl/pwm_duty_ramp_sequencer.sv | 119 +++++++++++
 tb/tb_pwm_duty_ramp_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM duty ramp sequencer: FSM encoding and default widths.
// The SPI register map also imports this package.
package pwm_seq_pkg;
  localparam int DEF_DUTY_W     = 8;
  localparam int DEF_INTERVAL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } seq_state_t;
endpackage

// File: rtl/pwm_seq_tick.sv
// Step-interval counter: counts 0..int_q and asserts tick on the terminal count.
module pwm_seq_tick import pwm_seq_pkg::*; #(
  parameter int INTERVAL_W = DEF_INTERVAL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [INTERVAL_W-1:0] int_q,
  output logic                  tick
);
  logic [INTERVAL_W-1:0] cnt;

  assign tick = en && (cnt == int_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pwm_duty_ramp_sequencer.sv
// Walks duty_out toward a latched target in saturating steps, one step per interval tick.
// Sits between the SPI duty register and pwm_peripheral for soft-start/stop.
module pwm_duty_ramp_sequencer import pwm_seq_pkg::*; #(
  parameter int                DUTY_W     = DEF_DUTY_W,
  parameter int                INTERVAL_W = DEF_INTERVAL_W,
  parameter logic [DUTY_W-1:0] RESET_DUTY = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  load,
  input  logic [DUTY_W-1:0]     load_value,
  input  logic [DUTY_W-1:0]     target,
  input  logic [DUTY_W-1:0]     step,
  input  logic [INTERVAL_W-1:0] interval,
  output logic [DUTY_W-1:0]     duty_out,
  output logic                  busy,
  output logic                  done
);
  seq_state_t            state_q, state_d;
  logic [DUTY_W-1:0]     tgt_q, stp_q, duty_d, step_res;
  logic [INTERVAL_W-1:0] int_q;
  logic                  latch, cnt_clr, cnt_en, tick;
  logic [DUTY_W:0]       up_sum, dn_thr;

  pwm_seq_tick #(.INTERVAL_W(INTERVAL_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .int_q (int_q),
    .tick  (tick)
  );

  // One extra bit so the sum/threshold can't wrap; result saturates at tgt_q.
  assign up_sum = {1'b0, duty_out} + {1'b0, stp_q};
  assign dn_thr = {1'b0, tgt_q} + {1'b0, stp_q};

  always_comb begin
    step_res = tgt_q;
    if (duty_out < tgt_q) begin
      if (up_sum < {1'b0, tgt_q}) step_res = up_sum[DUTY_W-1:0];
    end else if ({1'b0, duty_out} >= dn_thr) begin
      step_res = duty_out - stp_q;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_out;
    latch   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            latch   = 1'b1;
            cnt_clr = 1'b1;
            state_d = RAMP;
          end else if (load) begin
            duty_d = load_value;
          end
        end
        RAMP: begin
          if (abort) begin
            state_d = IDLE;
          end else if (start) begin
            latch   = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (tick) begin
              duty_d = step_res;
              if (step_res == tgt_q) state_d = DONE;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state_d = IDLE;
          end else if (start) begin
            latch   = 1'b1;
            cnt_clr = 1'b1;
            state_d = RAMP;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // busy/done are flopped from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_out <= RESET_DUTY;
      busy     <= 1'b0;
      done     <= 1'b0;
      tgt_q    <= '0;
      stp_q    <= '0;
      int_q    <= '0;
    end else begin
      state_q  <= state_d;
      duty_out <= duty_d;
      busy     <= (state_d == RAMP);
      done     <= (state_d == DONE);
      if (latch) begin
        tgt_q <= target;
        stp_q <= (step == '0) ? {{(DUTY_W-1){1'b0}}, 1'b1} : step;
        int_q <= interval;
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_ramp_sequencer.sv
// Directed bench for pwm_duty_ramp_sequencer: a per-cycle vector table plus hand-written
// sequences for reset, retarget, abort and enable freeze.
module tb_pwm_duty_ramp_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic        start = 1'b0, abort = 1'b0, load = 1'b0;
  logic [7:0]  load_value = '0, target = '0, step = '0;
  logic [15:0] interval = '0;
  logic [7:0]  duty_out;
  logic        busy, done;

  int n_chk = 0, n_pass = 0;

  pwm_duty_ramp_sequencer dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .abort(abort), .load(load),
    .load_value(load_value), .target(target), .step(step), .interval(interval),
    .duty_out(duty_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, ab, ld, en;
    logic [7:0]  lv, tg, sp;
    logic [15:0] iv;
    logic [7:0]  ed;
    logic        eb, edn;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] ed, input logic eb, input logic edn);
    n_chk++;
    if (duty_out === ed && busy === eb && done === edn) n_pass++;
    else $display("FAIL %s: got duty=%0d busy=%b done=%b, want duty=%0d busy=%b done=%b",
                  name, duty_out, busy, done, ed, eb, edn);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_in();
    start = 0; abort = 0; load = 0; ena = 1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1; load_value = v;
    cyc(1);
    load = 0;
  endtask

  task automatic do_start(input logic [7:0] t, input logic [7:0] s, input logic [15:0] i);
    start = 1; target = t; step = s; interval = i;
    cyc(1);
    start = 0;
  endtask

  function automatic vec_t mk(input logic st, ab, ld, en, input logic [7:0] lv, tg, sp,
                              input logic [15:0] iv, input logic [7:0] ed, input logic eb, edn);
    vec_t v;
    v.st = st; v.ab = ab; v.ld = ld; v.en = en; v.lv = lv; v.tg = tg; v.sp = sp; v.iv = iv;
    v.ed = ed; v.eb = eb; v.edn = edn;
    return v;
  endfunction

  initial begin
    //          st ab ld en  lv   tg   sp  iv   duty busy done
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    0, 0, 0));
    vecs.push_back(mk(0,0,1,1, 200,   0,   0, 0,  200, 0, 0));
    vecs.push_back(mk(1,0,0,1,   0,  10,  50, 0,  200, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,  150, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,  100, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,   50, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,   10, 0, 1));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,   10, 0, 0));
    vecs.push_back(mk(0,0,1,1, 250,   0,   0, 0,  250, 0, 0));
    vecs.push_back(mk(1,0,0,1,   0, 255, 200, 0,  250, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,  255, 0, 1));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,  255, 0, 0));
    vecs.push_back(mk(0,0,1,1,   5,   0,   0, 0,    5, 0, 0));
    vecs.push_back(mk(1,0,0,1,   0,   7,   0, 0,    5, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    6, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    7, 0, 1));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    7, 0, 0));
    vecs.push_back(mk(1,0,0,1,   0,   7,   3, 2,    7, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    7, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    7, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    7, 0, 1));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    7, 0, 0));
    vecs.push_back(mk(0,1,0,1,   0,   0,   0, 0,    7, 0, 0));
    vecs.push_back(mk(1,0,1,1,  99,   7,   1, 0,    7, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    7, 0, 1));
    vecs.push_back(mk(1,1,0,1,   0,  50,   1, 0,    7, 0, 0));
    vecs.push_back(mk(1,0,0,0,   0,  50,  40, 0,    7, 0, 0));
    vecs.push_back(mk(0,0,1,0,   9,   0,   0, 0,    7, 0, 0));
    vecs.push_back(mk(1,0,0,1,   0,   9,   1, 0,    7, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    8, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    9, 0, 1));
    vecs.push_back(mk(1,0,0,1,   0,   5,  10, 0,    9, 1, 0));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    5, 0, 1));
    vecs.push_back(mk(0,0,0,1,   0,   0,   0, 0,    5, 0, 0));

    cyc(2);
    chk("reset_state", 8'd0, 1'b0, 1'b0);
    rst = 0;

    foreach (vecs[k]) begin
      start = vecs[k].st; abort = vecs[k].ab; load = vecs[k].ld; ena = vecs[k].en;
      load_value = vecs[k].lv; target = vecs[k].tg; step = vecs[k].sp; interval = vecs[k].iv;
      cyc(1);
      chk($sformatf("vec%0d", k), vecs[k].ed, vecs[k].eb, vecs[k].edn);
    end
    idle_in();

    // Ramp up with interval 3: a step every 4 cycles, saturating at 100.
    do_load(0);
    do_start(100, 30, 3);
    chk("up_enter", 0, 1, 0);
    cyc(3); chk("up_pre_tick", 0, 1, 0);
    cyc(1); chk("up_30", 30, 1, 0);
    cyc(3); chk("up_hold30", 30, 1, 0);
    cyc(1); chk("up_60", 60, 1, 0);
    cyc(4); chk("up_90", 90, 1, 0);
    cyc(4); chk("up_100_done", 100, 0, 1);
    cyc(1); chk("up_idle", 100, 0, 0);

    // Retarget at duty 60: counter restarts with interval 1.
    do_load(0);
    do_start(100, 30, 3);
    cyc(8); chk("rt_at60", 60, 1, 0);
    do_start(20, 20, 1); chk("rt_enter", 60, 1, 0);
    cyc(1); chk("rt_wait", 60, 1, 0);
    cyc(1); chk("rt_40", 40, 1, 0);
    cyc(1); chk("rt_wait2", 40, 1, 0);
    cyc(1); chk("rt_20_done", 20, 0, 1);
    cyc(1); chk("rt_idle", 20, 0, 0);

    // Abort beats start in RAMP; duty holds, no done pulse.
    do_load(0);
    do_start(100, 30, 3);
    cyc(4); chk("ab_at30", 30, 1, 0);
    abort = 1; start = 1; target = 200; step = 5; interval = 0;
    cyc(1); idle_in();
    chk("ab_idle", 30, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1); chk("ab_quiet", 30, 0, 0);
    end
    do_load(77); chk("ab_load77", 77, 0, 0);
    do_start(200, 1, 100); chk("ab_ramp", 77, 1, 0);
    do_load(5); chk("ab_load_in_ramp", 77, 1, 0);
    abort = 1; cyc(1); abort = 0;
    chk("ab_clean", 77, 0, 0);

    // Enable low freezes counter and duty; start dropped while frozen.
    do_load(0);
    do_start(100, 30, 3);
    cyc(6); chk("en_before", 30, 1, 0);
    ena = 0;
    for (int i = 0; i < 10; i++) begin
      start = i[0]; target = 0; step = 99; interval = 0;
      cyc(1); chk("en_frozen", 30, 1, 0);
    end
    idle_in();
    cyc(1); chk("en_resume", 30, 1, 0);
    cyc(1); chk("en_tick60", 60, 1, 0);

    // Async reset mid-ramp takes effect without a clock edge.
    #3 rst = 1;
    #1 chk("rst_async", 0, 0, 0);
    cyc(1); rst = 0;
    cyc(3); chk("rst_stays_idle", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
